// File: rtl/vga_cam_pkg.sv
// Shared definitions for the camera-to-VGA frame buffer path.
// Covers RGB111 colours, capture FSM states and RGB565 channel MSB positions.
package vga_cam_pkg;

  localparam logic [2:0] RED_VGA   = 3'b100;
  localparam logic [2:0] GREEN_VGA = 3'b010;
  localparam logic [2:0] BLUE_VGA  = 3'b001;

  // Channel MSBs: R and the upper half of G arrive in the hi byte, B in the lo byte.
  localparam int unsigned HI_R_MSB = 7;
  localparam int unsigned HI_G_MSB = 2;
  localparam int unsigned LO_B_MSB = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VS,
    BYTE_HI,
    BYTE_LO,
    DONE
  } cam_state_t;

  function automatic logic [2:0] rgb565_to_rgb111(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[HI_R_MSB], hi[HI_G_MSB], lo[LO_B_MSB]};
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchroniser for an asynchronous camera signal, with one-clk rise/fall pulses.
module cam_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [2:0] sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sr <= '0;
    else      sr <= {sr[1:0], d};
  end

  assign q    = sr[1];
  assign rise = sr[1] & ~sr[2];
  assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/cam_frame_writer.sv
// Camera write side of the VGA frame buffer: RGB565 byte pairs -> RGB111 RAM writes.
// Optional macro CAM_DECIM_EN enables 2:1 decimation in X and Y.
module cam_frame_writer #(
  parameter int AW    = 15,
  parameter int DW    = 3,
  parameter int CAM_W = 160,
  parameter int CAM_H = 120
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          cam_pclk,
  input  logic          cam_href,
  input  logic          cam_vsync,
  input  logic [7:0]    cam_data,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          regwrite,
  output logic          frame_done,
  output logic          busy
);
  import vga_cam_pkg::*;

  localparam logic [AW-1:0] W_A = AW'(CAM_W);
  localparam logic [AW-1:0] H_A = AW'(CAM_H);
`ifdef CAM_DECIM_EN
  localparam logic [AW-1:0] LINE_STEP = AW'(CAM_W / 2);
`else
  localparam logic [AW-1:0] LINE_STEP = AW'(CAM_W);
`endif

  logic pclk_q, pclk_rise, pclk_fall;
  logic href_q, href_rise, href_fall;
  logic vs_q, vs_rise, vs_fall;
  logic unused_sync;

  cam_sync_edge u_sync_pclk (.clk(clk), .rst(rst), .d(cam_pclk),  .q(pclk_q), .rise(pclk_rise), .fall(pclk_fall));
  cam_sync_edge u_sync_href (.clk(clk), .rst(rst), .d(cam_href),  .q(href_q), .rise(href_rise), .fall(href_fall));
  cam_sync_edge u_sync_vs   (.clk(clk), .rst(rst), .d(cam_vsync), .q(vs_q),   .rise(vs_rise),   .fall(vs_fall));

  assign unused_sync = ^{pclk_q, pclk_fall, href_rise, vs_q};

  // Data takes the same two-stage path as pclk so it lines up with pclk_rise.
  logic [7:0] data_d1, data_d2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_d1 <= '0;
      data_d2 <= '0;
    end else begin
      data_d1 <= cam_data;
      data_d2 <= data_d1;
    end
  end

  cam_state_t    state;
  logic [AW-1:0] x, y, line_base, x_off;
  logic [7:0]    hi_byte;
  logic          keep_px, step_line;

  always_comb begin
`ifdef CAM_DECIM_EN
    keep_px   = (x < W_A) && (y < H_A) && !x[0] && !y[0];
    x_off     = x >> 1;
    step_line = !y[0];
`else
    keep_px   = (x < W_A) && (y < H_A);
    x_off     = x;
    step_line = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      addr_in    <= '0;
      data_in    <= '0;
      regwrite   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      x          <= '0;
      y          <= '0;
      line_base  <= '0;
      hi_byte    <= '0;
    end else begin
      regwrite   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: if (enable) begin
          state <= WAIT_VS;
          busy  <= 1'b1;
        end
        WAIT_VS: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (vs_fall) begin
            x         <= '0;
            y         <= '0;
            line_base <= '0;
            state     <= BYTE_HI;
          end
        end
        BYTE_HI, BYTE_LO: begin
          // Frame end wins over line end, which wins over a pixel byte.
          if (vs_rise) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end else if (href_fall) begin
            x <= '0;
            if (y < H_A) y <= y + 1'b1;
            if (step_line) line_base <= line_base + LINE_STEP;
            state <= BYTE_HI;
          end else if (pclk_rise && href_q) begin
            if (state == BYTE_HI) begin
              hi_byte <= data_d2;
              state   <= BYTE_LO;
            end else begin
              if (keep_px) begin
                regwrite <= 1'b1;
                addr_in  <= line_base + x_off;
                data_in  <= DW'(rgb565_to_rgb111(hi_byte, data_d2));
              end
              if (x < W_A) x <= x + 1'b1;
              state <= BYTE_HI;
            end
          end
        end
        DONE: begin
          if (enable) begin
            state <= WAIT_VS;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
